instr_fetch_decode: RTL and testbench
=====================================

Name: instr_fetch_decode

Overview:
- Instruction fetch and decode front end for the mini-ALU processor.
- Drives the instruction ROM address and receives the 28-bit instruction combinationally in the same cycle.
- Splits the instruction into opcode, destination, source and immediate fields, and issues them to the execute stage through a valid/stall handshake.
- Owns the program counter, accepts branch redirects from execute, and optionally folds JMP locally.

Parameters:
- ADDR_WIDTH, 16, ROM address / program counter width.
- INSTR_WIDTH, 28, instruction width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- Clock  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- oAddress  out  16  ROM address; equals the PC register.
- iInstruction  in  28  ROM data for oAddress, valid in the same cycle.
- iStall  in  1  execute cannot accept the issued instruction this cycle.
- iBranchTaken  in  1  execute resolved a taken BLE (or JMP when folding is off).
- iBranchTarget  in  16  redirect address, sampled when iBranchTaken=1.
- oValid  out  1  decode outputs hold a live instruction.
- oOpcode  out  4  iInstruction[27:24].
- oDestination  out  8  iInstruction[23:16]; register, or branch target for BLE/JMP.
- oSourceAddr0  out  8  iInstruction[15:8].
- oSourceAddr1  out  8  iInstruction[7:0].
- oImmediate  out  16  iInstruction[15:0].
- oPC  out  16  ROM address the issued instruction came from.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high.
  - Reset (at any time, including mid-stall or mid-redirect): PC=RESET_PC, FSM=IDLE, oValid=0, and all field outputs, oPC and oDestination = 0.
- FSM states: IDLE, RUN, HOLD.
  - IDLE: one cycle after reset deasserts. No issue. Go to RUN. The PC is not advanced.
  - RUN: load enable LE = !oValid || !iStall.
    - When LE=1: latch all fields from iInstruction, oPC<=PC, oValid<=1, PC<=PC+1.
    - When LE=0: go to HOLD; PC and outputs are unchanged.
  - HOLD: outputs and PC frozen while iStall=1. Return to RUN on the first cycle with iStall=0. That cycle performs an LE load as in RUN.
- Handshake:
  - An instruction is consumed on a cycle where oValid=1 and iStall=0.
  - Outputs are stable while oValid=1 and iStall=1.
  - A bubble (oValid=0) never blocks a load.
- Throughput: one instruction per cycle with no stalls. Issue latency is 1 cycle from the address appearing on oAddress.
- Redirect:
  - iBranchTaken=1 has priority over iStall and over a normal load.
  - Effect: PC<=iBranchTarget, oValid<=0 (flushes the younger issued instruction), FSM<=RUN.
  - The target instruction issues on the following cycle, giving exactly one bubble.
  - If Reset and iBranchTaken are both high, Reset wins.
- PC wrap: PC=16'hFFFF increments to 16'h0000; no error is flagged.
- Branch target fields: BLE/JMP targets are 8 bits in [23:16]. Execute zero-extends them before driving iBranchTarget. This block performs no arithmetic on them unless folding is enabled.
- Unknown opcodes are issued unchanged; no trap is raised.

Optional Feature:
- Macro: FETCH_JMP_FOLD_EN.
- Defined:
  - In RUN with LE=1 and opcode == `JMP, the JMP is not issued.
  - PC<={8'b0, iInstruction[23:16]} and oValid<=0, giving one bubble.
  - iBranchTaken in the same cycle still wins.
- Undefined: JMP issues like any instruction, and execute redirects via iBranchTaken.

Decomposition:
- Shared package / include holds:
  - opcode macros (`NOP, `LED, `BLE, `STO, `ADD, `SUB, `JMP, `SMUL, `IMUL, `IMUL2) and register macros (`R1..`R7);
  - field bit positions (OPCODE_MSB/LSB, DEST, SRC0, SRC1, IMM);
  - FSM state encodings.
- One natural sub-module, instr_field_split: purely combinational slicing of iInstruction into fields. It is reused by execute-side trace logic.

Test Plan:
- Reset release with ROM word 0 = {NOP, 24'd4000} and no stall:
  - IDLE for 1 cycle.
  - Next cycle oValid=1, oOpcode=NOP, oImmediate=16'd4000, oPC=0.
  - oAddress then steps 1, 2, 3.
- iStall=1 for 3 cycles while {STO, R7, 16'h0002} is issued: outputs and oAddress frozen for 3 cycles; the next instruction issues on the cycle after iStall falls.
- iBranchTaken=1 with iBranchTarget=8 while PC=11: oValid=0 next cycle, oAddress=8; the instruction at address 8 issues one cycle later with oPC=8.
- iBranchTaken=1 and iStall=1 in the same cycle: redirect occurs and stall is ignored for that cycle.
- JMP to 2 at address 15:
  - With FETCH_JMP_FOLD_EN: no JMP issued, one bubble, then oPC=2.
  - Without it: oOpcode=JMP is issued with oDestination=8'd2.
- Reset asserted during HOLD with PC=9: next cycle oValid=0, oAddress=0, FSM=IDLE.

Source files
------------

// File: rtl/instr_fetch_decode_pkg.sv
// Shared opcodes, register names, instruction field positions and
// fetch FSM encodings for the mini-ALU fetch/decode front end.
`ifndef INSTR_FETCH_DECODE_DEFS
`define INSTR_FETCH_DECODE_DEFS
`define NOP   4'd0
`define LED   4'd1
`define BLE   4'd2
`define STO   4'd3
`define ADD   4'd4
`define SUB   4'd5
`define JMP   4'd6
`define SMUL  4'd7
`define IMUL  4'd8
`define IMUL2 4'd9
`define R1    8'd1
`define R2    8'd2
`define R3    8'd3
`define R4    8'd4
`define R5    8'd5
`define R6    8'd6
`define R7    8'd7
`endif

package instr_fetch_decode_pkg;

  localparam int OPCODE_MSB = 27;
  localparam int OPCODE_LSB = 24;
  localparam int DEST_MSB   = 23;
  localparam int DEST_LSB   = 16;
  localparam int SRC0_MSB   = 15;
  localparam int SRC0_LSB   = 8;
  localparam int SRC1_MSB   = 7;
  localparam int SRC1_LSB   = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam logic [3:0] OP_NOP = `NOP;
  localparam logic [3:0] OP_STO = `STO;
  localparam logic [3:0] OP_JMP = `JMP;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [7:0]  dest;
    logic [7:0]  src0;
    logic [7:0]  src1;
    logic [15:0] imm;
  } dec_t;

endpackage

// File: rtl/instr_field_split.sv
// Combinational slicing of a 28-bit instruction word into its fields.
// Shared with execute-side trace logic.
module instr_field_split
  import instr_fetch_decode_pkg::*;
(
  input  logic [27:0] instr,
  output dec_t        fields
);

  // pure wiring: each field is a fixed bit range of the word
  always_comb begin
    fields        = '0;
    fields.opcode = instr[OPCODE_MSB:OPCODE_LSB];
    fields.dest   = instr[DEST_MSB:DEST_LSB];
    fields.src0   = instr[SRC0_MSB:SRC0_LSB];
    fields.src1   = instr[SRC1_MSB:SRC1_LSB];
    fields.imm    = instr[IMM_MSB:IMM_LSB];
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: PC, ROM address, field latch, valid/stall issue.
// Define FETCH_JMP_FOLD_EN to resolve JMP locally instead of in execute.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    INSTR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic [ADDR_WIDTH-1:0]  oAddress,
  input  logic [INSTR_WIDTH-1:0] iInstruction,
  input  logic                   iStall,
  input  logic                   iBranchTaken,
  input  logic [ADDR_WIDTH-1:0]  iBranchTarget,
  output logic                   oValid,
  output logic [3:0]             oOpcode,
  output logic [7:0]             oDestination,
  output logic [7:0]             oSourceAddr0,
  output logic [7:0]             oSourceAddr1,
  output logic [15:0]            oImmediate,
  output logic [ADDR_WIDTH-1:0]  oPC
);

  fetch_state_e          state_q;
  fetch_state_e          state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] pc_issue_q;
  logic                  valid_q;
  dec_t                  dec_q;
  dec_t                  fields;
  logic                  le;
  logic                  load;
  logic                  flush;
  logic                  jmp_hit;

  instr_field_split u_split (
    .instr  (iInstruction[27:0]),
    .fields (fields)
  );

  // next state, next PC and load/flush strobes; redirect has top priority
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    jmp_hit = 1'b0;
    le      = !valid_q || !iStall;
`ifdef FETCH_JMP_FOLD_EN
    jmp_hit = (fields.opcode == OP_JMP);
`endif
    if (iBranchTaken) begin
      state_d = RUN;
      flush   = 1'b1;
      pc_d    = iBranchTarget;
    end else begin
      unique case (state_q)
        IDLE: state_d = RUN;
        RUN, HOLD: begin
          if (le) begin
            state_d = RUN;
            if (jmp_hit) begin
              flush = 1'b1;
              pc_d  = {{(ADDR_WIDTH-8){1'b0}}, fields.dest};
            end else begin
              load = 1'b1;
              pc_d = pc_q + ADDR_WIDTH'(1);
            end
          end else begin
            state_d = HOLD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // PC and issued-instruction registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      dec_q      <= '0;
      pc_issue_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (flush) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q    <= 1'b1;
        dec_q      <= fields;
        pc_issue_q <= pc_q;
      end
    end
  end

  assign oAddress     = pc_q;
  assign oValid       = valid_q;
  assign oOpcode      = dec_q.opcode;
  assign oDestination = dec_q.dest;
  assign oSourceAddr0 = dec_q.src0;
  assign oSourceAddr1 = dec_q.src1;
  assign oImmediate   = dec_q.imm;
  assign oPC          = pc_issue_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: ROM model, stalls,
// redirects, JMP handling, PC wrap and reset during HOLD.
module tb_instr_fetch_decode;
  import instr_fetch_decode_pkg::*;

  typedef logic [59:0] exp_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        iStall;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic        oValid;
  logic [3:0]  oOpcode;
  logic [7:0]  oDestination;
  logic [7:0]  oSourceAddr0;
  logic [7:0]  oSourceAddr1;
  logic [15:0] oImmediate;
  logic [15:0] oPC;

  logic [27:0] mem [0:255];
  exp_t        sb [$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;

  instr_fetch_decode dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .oAddress      (oAddress),
    .iInstruction  (iInstruction),
    .iStall        (iStall),
    .iBranchTaken  (iBranchTaken),
    .iBranchTarget (iBranchTarget),
    .oValid        (oValid),
    .oOpcode       (oOpcode),
    .oDestination  (oDestination),
    .oSourceAddr0  (oSourceAddr0),
    .oSourceAddr1  (oSourceAddr1),
    .oImmediate    (oImmediate),
    .oPC           (oPC)
  );

  always #5 Clock = ~Clock;

  assign iInstruction = mem[oAddress[7:0]];

  function automatic exp_t mk(input logic [15:0] pc);
    logic [27:0] w;
    w = mem[pc[7:0]];
    return {pc, w[27:24], w[23:16], w[15:8], w[7:0], w[15:0]};
  endfunction

  function automatic exp_t got();
    return {oPC, oOpcode, oDestination,
            oSourceAddr0, oSourceAddr1, oImmediate};
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    iStall = 1'b0;
    iBranchTaken = 1'b0;
    iBranchTarget = 16'h0;
    sb.delete();
    repeat (2) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge Clock);
    n_cmp++;
    if ({oValid, oAddress, oPC, oOpcode, oDestination, oImmediate} !== '0) begin
      n_bad++;
      $display("FAIL reset_vals: got v=%b a=%h pc=%h op=%h d=%h i=%h want all 0",
               oValid, oAddress, oPC, oOpcode, oDestination, oImmediate);
    end
    for (int p = 0; p < 3; p++) sb.push_back(mk(16'(p)));
    for (int c = 0; c < 5; c++) begin
      @(posedge Clock); #1;
      Reset = 1'b0; iStall = 1'b0; iBranchTaken = 1'b0;
      @(negedge Clock);
      n_cmp++;
      if (oAddress !== ((c < 2) ? 16'd0 : 16'(c - 1))) begin
        n_bad++;
        $display("FAIL reset_addr c=%0d: got %h want %h", c, oAddress,
                 (c < 2) ? 16'd0 : 16'(c - 1));
      end
      if (c < 2) begin
        n_cmp++;
        if (oValid !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_idle c=%0d: got oValid=%b want 0", c, oValid);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (oImmediate !== 16'd4000 || oOpcode !== OP_NOP) begin
          n_bad++;
          $display("FAIL reset_first: got op=%h imm=%0d want op=0 imm=4000",
                   oOpcode, oImmediate);
        end
      end
      if (oValid && !iStall) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL reset_issue: got extra pc=%h want none", oPC);
        end else begin
          e = sb.pop_front();
          if (got() !== e) begin
            n_bad++;
            $display("FAIL reset_issue: got %h want %h", got(), e);
          end
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL reset_left: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int p = 0; p < 5; p++) sb.push_back(mk(16'(p)));
    for (int c = 0; c < 10; c++) begin
      @(posedge Clock); #1;
      Reset = 1'b0; iBranchTaken = 1'b0;
      iStall = (c >= 5 && c <= 7);
      @(negedge Clock);
      if (c >= 5 && c <= 8) begin
        n_cmp++;
        if ({oValid, oPC, oOpcode, oDestination, oImmediate, oAddress} !==
            {1'b1, 16'd3, OP_STO, 8'd7, 16'h0002, 16'd4}) begin
          n_bad++;
          $display("FAIL stall_hold c=%0d: got v=%b pc=%h op=%h d=%h i=%h a=%h want 1/3/3/7/2/4",
                   c, oValid, oPC, oOpcode, oDestination, oImmediate, oAddress);
        end
      end
      if (c == 9) begin
        n_cmp++;
        if (oPC !== 16'd4 || oAddress !== 16'd5) begin
          n_bad++;
          $display("FAIL stall_resume: got pc=%h a=%h want 4/5", oPC, oAddress);
        end
      end
      if (oValid && !iStall) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL stall_issue: got extra pc=%h want none", oPC);
        end else begin
          e = sb.pop_front();
          if (got() !== e) begin
            n_bad++;
            $display("FAIL stall_issue: got %h want %h", got(), e);
          end
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL stall_left: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int p = 0; p <= 10; p++) sb.push_back(mk(16'(p)));
    sb.push_back(mk(16'd8));
    sb.push_back(mk(16'h0020));
    for (int c = 0; c < 18; c++) begin
      @(posedge Clock); #1;
      Reset = 1'b0;
      iStall = (c == 15);
      iBranchTaken = (c == 12 || c == 15);
      iBranchTarget = (c == 12) ? 16'd8 : 16'h0020;
      @(negedge Clock);
      if (c == 12) begin
        n_cmp++;
        if (oAddress !== 16'd11) begin
          n_bad++;
          $display("FAIL br_pre: got a=%h want 000b", oAddress);
        end
      end
      if (c == 13 || c == 16) begin
        n_cmp++;
        if (oValid !== 1'b0 || oAddress !== ((c == 13) ? 16'd8 : 16'h0020)) begin
          n_bad++;
          $display("FAIL br_bubble c=%0d: got v=%b a=%h want 0/%h", c,
                   oValid, oAddress, (c == 13) ? 16'd8 : 16'h0020);
        end
      end
      if (oValid && !iStall) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL br_issue: got extra pc=%h want none", oPC);
        end else begin
          e = sb.pop_front();
          if (got() !== e) begin
            n_bad++;
            $display("FAIL br_issue: got %h want %h", got(), e);
          end
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL br_left: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_jmp();
    do_reset();
`ifdef FETCH_JMP_FOLD_EN
    for (int p = 0; p <= 14; p++) sb.push_back(mk(16'(p)));
    sb.push_back(mk(16'd2));
    sb.push_back(mk(16'd3));
`else
    for (int p = 0; p <= 15; p++) sb.push_back(mk(16'(p)));
    sb.push_back(mk(16'd2));
`endif
    for (int c = 0; c < 20; c++) begin
      @(posedge Clock); #1;
      Reset = 1'b0; iStall = 1'b0;
`ifdef FETCH_JMP_FOLD_EN
      iBranchTaken = 1'b0;
`else
      iBranchTaken = (c == 17);
`endif
      iBranchTarget = 16'd2;
      @(negedge Clock);
`ifdef FETCH_JMP_FOLD_EN
      if (c == 17) begin
        n_cmp++;
        if (oValid !== 1'b0 || oAddress !== 16'd2) begin
          n_bad++;
          $display("FAIL jmp_fold: got v=%b a=%h want 0/0002", oValid, oAddress);
        end
      end
`else
      if (c == 17) begin
        n_cmp++;
        if (oValid !== 1'b1 || oOpcode !== OP_JMP || oDestination !== 8'd2) begin
          n_bad++;
          $display("FAIL jmp_issue: got v=%b op=%h d=%h want 1/6/02",
                   oValid, oOpcode, oDestination);
        end
      end
      if (c == 18) begin
        n_cmp++;
        if (oValid !== 1'b0 || oAddress !== 16'd2) begin
          n_bad++;
          $display("FAIL jmp_bubble: got v=%b a=%h want 0/0002", oValid, oAddress);
        end
      end
`endif
      if (oValid && !iStall) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL jmp_seq: got extra pc=%h want none", oPC);
        end else begin
          e = sb.pop_front();
          if (got() !== e) begin
            n_bad++;
            $display("FAIL jmp_seq: got %h want %h", got(), e);
          end
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL jmp_left: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    sb.push_back(mk(16'h0000));
    sb.push_back(mk(16'hFFFE));
    sb.push_back(mk(16'hFFFF));
    sb.push_back(mk(16'h0000));
    for (int c = 0; c < 7; c++) begin
      @(posedge Clock); #1;
      Reset = 1'b0; iStall = 1'b0;
      iBranchTaken = (c == 2);
      iBranchTarget = 16'hFFFE;
      @(negedge Clock);
      if (c == 5) begin
        n_cmp++;
        if (oAddress !== 16'h0000) begin
          n_bad++;
          $display("FAIL wrap_addr: got a=%h want 0000", oAddress);
        end
      end
      if (oValid && !iStall) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL wrap_issue: got extra pc=%h want none", oPC);
        end else begin
          e = sb.pop_front();
          if (got() !== e) begin
            n_bad++;
            $display("FAIL wrap_issue: got %h want %h", got(), e);
          end
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL wrap_left: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_reset_hold();
    do_reset();
    for (int p = 0; p <= 7; p++) sb.push_back(mk(16'(p)));
    sb.push_back(mk(16'd0));
    for (int c = 0; c < 15; c++) begin
      @(posedge Clock); #1;
      Reset = (c == 11);
      iStall = (c == 10 || c == 11);
      iBranchTaken = (c == 11);
      iBranchTarget = 16'h0033;
      @(negedge Clock);
      if (c == 11) begin
        n_cmp++;
        if (oValid !== 1'b1 || oAddress !== 16'd9) begin
          n_bad++;
          $display("FAIL rh_hold: got v=%b a=%h want 1/0009", oValid, oAddress);
        end
      end
      if (c == 12) begin
        n_cmp++;
        if ({oValid, oAddress, oPC, oOpcode, oDestination,
             oSourceAddr0, oSourceAddr1, oImmediate} !== '0) begin
          n_bad++;
          $display("FAIL rh_clear: got v=%b a=%h pc=%h op=%h d=%h i=%h want all 0",
                   oValid, oAddress, oPC, oOpcode, oDestination, oImmediate);
        end
      end
      if (c == 13) begin
        n_cmp++;
        if (oValid !== 1'b0 || oAddress !== 16'd0) begin
          n_bad++;
          $display("FAIL rh_idle: got v=%b a=%h want 0/0000", oValid, oAddress);
        end
      end
      if (oValid && !iStall) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL rh_issue: got extra pc=%h want none", oPC);
        end else begin
          e = sb.pop_front();
          if (got() !== e) begin
            n_bad++;
            $display("FAIL rh_issue: got %h want %h", got(), e);
          end
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL rh_left: got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      mem[i] = {4'h4, b, ~b, b ^ 8'h5A};
    end
    mem[0]  = {OP_NOP, 24'd4000};
    mem[3]  = {OP_STO, 8'd7, 16'h0002};
    mem[15] = {OP_JMP, 8'd2, 16'h0000};
    test_reset();
    test_stall();
    test_branch();
    test_jmp();
    test_wrap();
    test_reset_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
